// File: rtl/mux4_1_if.sv
// Bundle for the 4-to-1 select stage: four data inputs, the select code,
// and the combinational output with its two registered outputs.
interface mux4_1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] z_q;
  logic [3:0]       sel_oh_q;

  // master drives data and select; slave is the mux itself
  modport master (
    output d0, d1, d2, d3, sel,
    input  z, z_q, sel_oh_q
  );

  modport slave (
    input  d0, d1, d2, d3, sel,
    output z, z_q, sel_oh_q
  );
endinterface

// File: rtl/mux4_1.sv
// 4-to-1 datapath mux: zero-latency output z plus registered z_q and a
// registered one-hot decode of sel for timing-critical downstream logic.
module mux4_1 #(
  parameter int WIDTH = 1
) (
  input logic     clk,
  input logic     rst_n,
  mux4_1_if.slave bus
);

  logic [WIDTH-1:0] z_c;
  logic [3:0]       sel_oh_c;

  // sel[1] picks the {d2,d3} pair, sel[0] picks within it; X/Z falls back to d0
  always_comb begin
    z_c = bus.d0;
    unique case (bus.sel)
      2'b00:   z_c = bus.d0;
      2'b01:   z_c = bus.d1;
      2'b10:   z_c = bus.d2;
      2'b11:   z_c = bus.d3;
      default: z_c = bus.d0;
    endcase
  end

  always_comb begin
    sel_oh_c = 4'b0001 << bus.sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.z_q      <= '0;
      bus.sel_oh_q <= 4'b0000;
    end else begin
      bus.z_q      <= z_c;
      bus.sel_oh_q <= sel_oh_c;
    end
  end

  assign bus.z = z_c;

endmodule

// File: tb/tb_mux4_1.sv
// Bench for mux4_1: directed scenarios then randomized traffic, checked
// against an array-indexed reference with an expected queue for registers.
module tb_mux4_1;
  localparam int W = 4;

  logic clk;
  logic rst_n;

  mux4_1_if #(.WIDTH(W)) bus ();

  mux4_1 #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt;
  int err_cnt;

  logic [W-1:0]   m_d [4];
  int             m_sel;
  logic [W+3:0]   exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: apply all inputs, then check the combinational output
  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d,
                        input int s);
    m_d[0] = a; m_d[1] = b; m_d[2] = c; m_d[3] = d;
    m_sel  = s;
    bus.d0 = a; bus.d1 = b; bus.d2 = c; bus.d3 = d;
    bus.sel = 2'(s);
    #1;
    check("z", 32'(bus.z), 32'(m_d[m_sel]));
  endtask

  // one clock edge: predict registers, then compare against queue head
  task automatic tick();
    logic [3:0]   oh;
    logic [W-1:0] zq;
    logic [W+3:0] e;
    oh = '0;
    zq = '0;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) oh[i] = (m_sel == i);
      zq = m_d[m_sel];
    end
    exp_q.push_back({oh, zq});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("z_q", 32'(bus.z_q), 32'(e[W-1:0]));
    check("sel_oh_q", 32'(bus.sel_oh_q), 32'(e[W+3:W]));
  endtask

  task automatic check_regs_clear(input string tag);
    check({tag, "_z_q"}, 32'(bus.z_q), 32'd0);
    check({tag, "_oh"}, 32'(bus.sel_oh_q), 32'd0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0; bus.sel = 2'b00;
    @(negedge clk);

    // reset state; z live during reset
    check_regs_clear("reset");
    set_in(0, 1, 1, 1, 0);
    set_in(1, 1, 1, 1, 0);
    check_regs_clear("reset_hold");
    rst_n = 1'b1;
    #1;
    check_regs_clear("release_pre_edge");

    // scenario 1-4: selection and unselected inputs ignored
    set_in(0, 1, 1, 1, 0);
    set_in(1, 1, 1, 1, 0);
    set_in(0, 1, 1, 1, 0);
    set_in(0, 0, 1, 1, 0);
    set_in(0, 0, 1, 1, 1);
    set_in(0, 1, 1, 1, 1);
    set_in(0, 1, 1, 0, 1);
    set_in(0, 1, 1, 0, 3);
    set_in(0, 1, 1, 0, 2);
    set_in(0, 1, 0, 0, 2);

    // scenario 5: registered path latency
    set_in(0, 0, 1, 0, 2);
    tick();
    set_in(0, 0, 1, 0, 0);
    check("z_q_holds", 32'(bus.z_q), 32'd1);
    tick();

    // full-width vectors
    set_in(4'hA, 4'h5, 4'hC, 4'h3, 3);
    tick();
    set_in(4'hA, 4'h5, 4'hC, 4'h3, 1);
    tick();

    // scenario 6: async reset between edges
    set_in(4'hF, 4'h1, 4'h2, 4'h4, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check_regs_clear("async_rst");
    set_in(4'h7, 4'h1, 4'h2, 4'h4, 2);
    tick();
    rst_n = 1'b1;
    #1;
    check_regs_clear("rst_release");
    tick();

    // randomized traffic with occasional mid-cycle reset pulses
    for (int n = 0; n < 300; n++) begin
      set_in(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             int'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        #1;
        check_regs_clear("rand_rst");
        rst_n = 1'b1;
      end
      tick();
    end

    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
